// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/control unit.
// Forwarding selects, FSM states and branch-resolution stage numbers.
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;

endpackage

// File: rtl/fwd_sel.sv
// Single-operand forwarding comparator; MEM result wins over WB.
// Register 0 is hard-zero and never forwarded.
module fwd_sel
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_we,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_RF;
    if (mem_we && mem_rd != '0 && mem_rd == src)
      sel = FWD_MEM;
    else if (wb_we && wb_rd != '0 && wb_rd == src)
      sel = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and control unit: forwarding, load-use interlock, multi-cycle
// EX occupancy FSM, redirect flush and a saturating stall counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int MUL_LAT  = 4,
  parameter int BR_STAGE = 3,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_rs_used_i,
  input  logic              id_rt_used_i,
  input  logic [REG_AW-1:0] ex_rs_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_valid_i,
  input  logic              ex_regwrite_i,
  input  logic              ex_memread_i,
  input  logic              ex_multi_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_regwrite_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_regwrite_i,
  input  logic              redirect_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              pc_stall_o,
  output logic              ifid_stall_o,
  output logic              idex_stall_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic              exmem_bubble_o,
  output logic              multi_busy_o,
  output logic              multi_abort_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam bit MULTI_EN = (MUL_LAT > 1);
  localparam logic [3:0] OCC_LD =
    MULTI_EN ? 4'(MUL_LAT - 2) : 4'd0;

  state_t     state, state_n;
  logic [3:0] occ, occ_n;
  logic       abort_n;
  logic       detect;
  logic       multi_stall;
  logic       load_use;
  logic       rs_hit, rt_hit;

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .src    (ex_rs_i),
    .mem_rd (mem_rd_i),
    .mem_we (mem_regwrite_i),
    .wb_rd  (wb_rd_i),
    .wb_we  (wb_regwrite_i),
    .sel    (fwd_a_o)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .src    (ex_rt_i),
    .mem_rd (mem_rd_i),
    .mem_we (mem_regwrite_i),
    .wb_rd  (wb_rd_i),
    .wb_we  (wb_regwrite_i),
    .sel    (fwd_b_o)
  );

  // ex_regwrite_i is implied by a load; kept for port completeness
  logic unused_ok;
  assign unused_ok = ex_regwrite_i;

  assign rs_hit = id_rs_used_i && (id_rs_i == ex_rd_i);
  assign rt_hit = id_rt_used_i && (id_rt_i == ex_rd_i);
  assign load_use = ex_valid_i && ex_memread_i &&
                    (ex_rd_i != '0) && (rs_hit || rt_hit);

  assign detect = MULTI_EN && ex_valid_i && ex_multi_i;

  always_comb begin
    state_n     = state;
    occ_n       = occ;
    multi_stall = 1'b0;
    abort_n     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (detect) begin
          multi_stall = 1'b1;
          occ_n       = OCC_LD;
          state_n     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (occ != 4'd0) begin
          multi_stall = 1'b1;
          occ_n       = occ - 4'd1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // A MEM-stage redirect kills the op sitting in EX
    if (redirect_i && BR_STAGE == STG_MEM &&
        (state == ST_BUSY || detect)) begin
      state_n = ST_IDLE;
      occ_n   = 4'd0;
      abort_n = 1'b1;
    end
  end

  always_comb begin
    pc_stall_o     = 1'b0;
    ifid_stall_o   = 1'b0;
    idex_stall_o   = 1'b0;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    exmem_bubble_o = 1'b0;
    if (redirect_i) begin
      ifid_flush_o   = 1'b1;
      idex_bubble_o  = (BR_STAGE >= STG_EX);
      exmem_bubble_o = (BR_STAGE == STG_MEM);
    end else if (multi_stall) begin
      pc_stall_o     = 1'b1;
      ifid_stall_o   = 1'b1;
      idex_stall_o   = 1'b1;
      exmem_bubble_o = 1'b1;
    end else if (load_use) begin
      pc_stall_o    = 1'b1;
      ifid_stall_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      occ           <= 4'd0;
      multi_abort_o <= 1'b0;
      stall_cnt_o   <= '0;
    end else begin
      state         <= state_n;
      occ           <= occ_n;
      multi_abort_o <= abort_n;
      if (pc_stall_o && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

  assign multi_busy_o = (state == ST_BUSY);

endmodule
